// File: rtl/acc_burst_framer_if.sv
// decoupled_vr_if: valid/ready/data channel used on both sides of acc_burst_framer.
// The producer drives valid and data, and the consumer drives ready. A beat
// transfers on any rising clock edge where valid and ready are both high.
interface decoupled_vr_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/acc_burst_framer.sv
// acc_burst_framer: forwards 64-bit words through one registered output slot
// and counts beats modulo BURST_LEN. A flush closes a partially filled frame
// by inserting zero words. The accelerator downstream therefore only ever
// receives whole BURST_LEN-word frames.
//
// Optional feature: define ACC_BURST_FRAMER_STATS_EN to implement the
// burst_cnt/pad_cnt statistics registers. When the macro is undefined, both
// ports are tied to zero and no counter flops are built.
//
// BURST_LEN must be a power of two and at least 2. DATA_WIDTH must match the
// data width of the connected decoupled_vr_if instances.
module acc_burst_framer #(
    parameter int BURST_LEN  = 128,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    decoupled_vr_if.slave         in_data,
    decoupled_vr_if.master        out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [31:0]           burst_cnt,
    output logic [31:0]           pad_cnt
);
    localparam int              CW       = $clog2(BURST_LEN);
    localparam logic [CW-1:0]   LAST_IDX = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_PAD  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0]   out_dat_q, out_dat_d;
    logic                    out_last_q, out_last_d;

    logic                    slot_load;
    logic                    in_acc;
    logic                    pad_load;
    logic                    beat;
    logic                    at_last;

    // The slot can take a new beat when it is empty or is being drained in
    // this same cycle. The path from out_data.ready to in_data.ready is
    // combinational on purpose, because there is no skid buffer.
    assign slot_load     = !out_vld_q || out_data.ready;
    assign in_data.ready = (state_q != S_PAD) && slot_load;
    assign in_acc        = in_data.valid && in_data.ready;
    assign pad_load      = (state_q == S_PAD) && slot_load;
    assign beat          = in_acc || pad_load;
    assign at_last       = (cnt_q == LAST_IDX);

    // Next-state logic for the slot, the beat counter and the frame state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the block leaves it unassigned (which would infer a latch).
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        cnt_d      = cnt_q;
        state_d    = state_q;

        if (slot_load) begin
            out_vld_d  = beat;
            out_last_d = beat && at_last;
            if (in_acc) begin
                out_dat_d = in_data.data;
            end else if (pad_load) begin
                out_dat_d = '0;
            end
        end

        // The counter is sized so that the increment wraps naturally at BURST_LEN.
        if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE:  if (in_acc)          state_d = S_PASS;
            S_PASS:  if (beat && at_last) state_d = S_IDLE;
            S_PAD:   if (beat && at_last) state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase

        // A flush counts the coincident word first. It only starts padding if
        // that update leaves the frame open. It is ignored while padding.
        if (flush && (state_q != S_PAD) && (cnt_d != '0)) begin
            state_d = S_PAD;
        end
    end

    // State register: the frame FSM, the beat counter and the output slot.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values no matter how the statements are ordered.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            // NOTE: the data register is reset as well, so out_data.data reads zero after reset instead of X.
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_data.valid = out_vld_q;
    assign out_data.data  = out_dat_q;
    assign out_last       = out_last_q;
    assign busy           = (state_q != S_IDLE) || out_vld_q;

`ifdef ACC_BURST_FRAMER_STATS_EN
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] pad_cnt_q,   pad_cnt_d;

    // A frame is counted when its last beat hands off downstream. Pad words
    // are counted when they load into the slot. Both counters wrap at 2^32.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        if (out_vld_q && out_data.ready && out_last_q) begin
            burst_cnt_d = burst_cnt_q + 32'd1;
        end
        if (pad_load) begin
            pad_cnt_d = pad_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= '0;
            pad_cnt_q   <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign pad_cnt   = pad_cnt_q;
`else
    assign burst_cnt = '0;
    assign pad_cnt   = '0;
`endif

endmodule

// File: doc/acc_burst_framer.md
# acc_burst_framer

Upstream feeder for the fixed-length accelerator stage. It accepts 64-bit words from the cohort consumer FIFO and forwards them through a registered output slot, keeping a running beat count modulo `BURST_LEN`. On a `flush` request, it closes any partially filled burst by inserting zero words. The downstream accelerator therefore always receives whole `BURST_LEN`-word frames and never stalls mid-frame waiting for data that will not arrive.

## Interface
Parameters:
- `BURST_LEN`, 128: words per frame; power of two, ≥ 2.
- `DATA_WIDTH`, 64: word width; must match the `decoupled_vr_if` data width.

Ports:
- `clk` (in, 1): the single clock.
- `rst` (in, 1): reset, synchronous and active-high.
- `flush` (in, 1): single-cycle request to pad the current partial frame to completion.
- `in_data` (`decoupled_vr_if.slave`, `DATA_WIDTH`): upstream words (valid/ready/data).
- `out_data` (`decoupled_vr_if.master`, `DATA_WIDTH`): frames towards the accelerator.
- `out_last` (out, 1): asserted with the final beat of each frame (count == `BURST_LEN`-1).
- `busy` (out, 1): high when state ≠ `S_IDLE` or the output slot is occupied.
- `burst_cnt` (out, 32): frames completed. Functional only with the stats macro (see Configuration).
- `pad_cnt` (out, 32): zero words inserted. Functional only with the stats macro.

## Operation
- **Output slot:** one register holding `out_vld_r` and `out_dat_r`. The slot "loads" when it is empty, or when `out_data.valid & out_data.ready` in the same cycle (full throughput).
- **Beat counter:** `cnt_r`, `$clog2(BURST_LEN)` bits. It increments on every slot load, real or pad, and wraps from `BURST_LEN`-1 to 0.
- **States:**
  - `S_IDLE`: `cnt_r`==0 and no flush pending.
    - An accepted input word moves the block to `S_PASS`.
  - `S_PASS`: `in_data.ready` = slot can load. Accepted words load the slot.
    - If `cnt_r` wraps, go to `S_IDLE`.
    - If `flush` is seen with the post-update `cnt_r` ≠ 0, go to `S_PAD`.
  - `S_PAD`: `in_data.ready`=0. Each slot load inserts data `'0` and counts as a pad beat.
    - When `cnt_r` wraps, go to `S_IDLE`.
- **Flush ignored** when:
  - it arrives at a frame boundary (post-update `cnt_r`==0), including `S_IDLE`;
  - it arrives while already in `S_PAD`.
- **Flush coincident with an accepted input word:** the word is counted first. Padding starts on the next load, unless that word completed the frame.
- **`out_last`** is registered with the slot (set when the loaded beat index is `BURST_LEN`-1).
- **`out_data.valid`** must not drop while the slot is held (valid/ready rule). Data is stable while valid & !ready.

## Timing
- **Reset values:**
  - `out_data.valid`=0, `out_data.data`=0, `out_last`=0, `busy`=0;
  - `cnt_r`=0, state=`S_IDLE`;
  - `burst_cnt`=`pad_cnt`=0;
  - `in_data.ready`=1 from the first cycle after reset deassertion.
- **Reset mid-frame** discards the slot and the count. There is no partial-frame recovery; the next word starts a new frame.
- **Latency:** an input word accepted in cycle N appears on `out_data` in cycle N+1.
- **Throughput:** one word per cycle while downstream is ready.
- **Pad rate:** one zero word per cycle while downstream is ready. Padding a frame with k real words takes `BURST_LEN`-k cycles minimum.
- **Combinational paths:**
  - `in_data.ready` depends combinationally on `out_data.ready` (no skid buffer).
  - There are no combinational paths from `in_data.valid` to outputs.
- **Counter updates:** `burst_cnt` increments on the handshake of an `out_last` beat. `pad_cnt` increments per pad slot load. Both wrap at 2^32.

## Configuration
- **Macro:** `ACC_BURST_FRAMER_STATS_EN`.
- **Defined:** `burst_cnt`/`pad_cnt` registers are implemented and update as specified in Timing.
- **Undefined:** both ports are tied to constant 0 and no counter flops are synthesised. The port list is unchanged.

## Test plan
- **Streaming:** `BURST_LEN`=128, 256 consecutive words 1..256 with `out_data.ready`=1.
  - Outputs 1..256 appear in order, each one cycle after acceptance.
  - `out_last` on words 128 and 256.
  - `burst_cnt`=2, `pad_cnt`=0.
- **Partial flush:** 5 words, then `flush`.
  - `in_data.ready` drops; 123 zero words follow word 5.
  - `out_last` on the 128th beat; `pad_cnt`=123; state returns to `S_IDLE`.
- **Boundary flush:** `flush` asserted together with the acceptance of word 128, and `flush` in `S_IDLE`.
  - No pad beats in either case; `pad_cnt` unchanged.
- **Backpressure:** random `out_data.ready` (50%) during pass and pad.
  - No dropped or duplicated words; data stable while valid & !ready; order preserved.
- **Reset mid-operation:** `rst` pulsed at beat 40 of a padded frame.
  - Next cycle: `out_data.valid`=0, counters 0, `in_data.ready`=1.
  - The next frame's `out_last` falls on its own 128th word.
- **Stats macro off:** repeat the partial-flush test.
  - `burst_cnt`/`pad_cnt` read 0; data behaviour identical.
